// File: rtl/riscv_core_pkg.sv
// Shared state encoding and funct3 codes for the M-extension sequencing controller.
package riscv_core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/riscv_core_div_fastpath.sv
// Divide-by-zero and signed-overflow detection with the architecturally defined result.
// funct3[0] = unsigned, funct3[1] = remainder; only meaningful for divide opcodes.
module riscv_core_div_fastpath #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [1:0]      funct3,
  input  logic            isword,
  output logic            hit,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic [XLEN-1:0] int_min;
  logic            div_zero;
  logic            overflow;

  // W ops work on sign-extended low halves so one compare covers both widths
  always_comb begin
    dividend = isword ? XLEN'($signed(src_a[31:0])) : src_a;
    divisor  = isword ? XLEN'($signed(src_b[31:0])) : src_b;
    int_min  = isword ? XLEN'($signed(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (divisor == '0);
    overflow = ~funct3[0] & (dividend == int_min) & (divisor == '1);
    hit      = div_zero | overflow;
    if (div_zero) result = funct3[1] ? dividend : '1;
    else          result = funct3[1] ? '0 : dividend;
  end

endmodule

// File: rtl/riscv_core_mdu_ctrl.sv
// Sequencer between EX issue and the mul/div wrapper: captures operands, drives the
// wrapper, resolves divide corner cases locally and stalls EX until the result is ready.
//
// state | meaning
// IDLE  | waiting for valid; captures operands on accept
// MUL   | single enable cycle, combinational multiplier result registered
// DIV   | enable held until wrapper done
// DONE  | result presented for one cycle
module riscv_core_mdu_ctrl
  import riscv_core_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            i_mdu_ctrl_clk,
  input  logic            i_mdu_ctrl_rstn,
  input  logic            i_mdu_ctrl_valid,
  input  logic [2:0]      i_mdu_ctrl_funct3,
  input  logic            i_mdu_ctrl_isword,
  input  logic [XLEN-1:0] i_mdu_ctrl_srcA,
  input  logic [XLEN-1:0] i_mdu_ctrl_srcB,
  input  logic            i_mdu_ctrl_flush,
  output logic            o_mdu_ctrl_stall,
  output logic            o_mdu_ctrl_done,
  output logic [XLEN-1:0] o_mdu_ctrl_result,
  output logic            o_mdu_ctrl_busy,
  output logic [XLEN-1:0] o_md_srcA,
  output logic [XLEN-1:0] o_md_srcB,
  output logic [3:0]      o_md_control,
  output logic            o_md_isword,
  output logic            o_md_en,
  input  logic            i_md_done,
  input  logic [XLEN-1:0] i_md_result
);

  mdu_state_t      state_q, state_d;
  logic [2:0]      funct3_q;
  logic            isword_q;
  logic [XLEN-1:0] src_a_q, src_b_q, result_q;
  logic            capture, load_fast, load_md, md_en;
  logic            fast_hit;
  logic [XLEN-1:0] fast_result;

  // Evaluated on the incoming operands so a corner case completes straight from IDLE
  riscv_core_div_fastpath #(.XLEN(XLEN)) u_fastpath (
    .src_a  (i_mdu_ctrl_srcA),
    .src_b  (i_mdu_ctrl_srcB),
    .funct3 (i_mdu_ctrl_funct3[1:0]),
    .isword (i_mdu_ctrl_isword),
    .hit    (fast_hit),
    .result (fast_result)
  );

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    load_fast = 1'b0;
    load_md   = 1'b0;
    md_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_mdu_ctrl_valid && !i_mdu_ctrl_flush) begin
          capture = 1'b1;
          if (!i_mdu_ctrl_funct3[2]) begin
            state_d = MUL;
          end else if (fast_hit) begin
            load_fast = 1'b1;
            state_d   = DONE;
          end else begin
            state_d = DIV;
          end
        end
      end
      MUL: begin
        if (i_mdu_ctrl_flush) begin
          state_d = IDLE;
        end else begin
          md_en   = 1'b1;
          load_md = 1'b1;
          state_d = DONE;
        end
      end
      DIV: begin
        if (i_mdu_ctrl_flush) begin
          state_d = IDLE;
        end else begin
          md_en = 1'b1;
          if (i_md_done) begin
            load_md = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_mdu_ctrl_clk or negedge i_mdu_ctrl_rstn) begin
    if (!i_mdu_ctrl_rstn) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      isword_q <= 1'b0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        funct3_q <= i_mdu_ctrl_funct3;
        isword_q <= i_mdu_ctrl_isword;
        src_a_q  <= i_mdu_ctrl_srcA;
        src_b_q  <= i_mdu_ctrl_srcB;
      end
      if (load_fast)    result_q <= fast_result;
      else if (load_md) result_q <= i_md_result;
    end
  end

  assign o_mdu_ctrl_done   = (state_q == DONE);
  assign o_mdu_ctrl_busy   = (state_q != IDLE);
  assign o_mdu_ctrl_stall  = i_mdu_ctrl_valid & ~o_mdu_ctrl_done;
  assign o_mdu_ctrl_result = result_q;
  assign o_md_srcA         = src_a_q;
  assign o_md_srcB         = src_b_q;
  assign o_md_control      = {1'b0, funct3_q};
  assign o_md_isword       = isword_q;
  assign o_md_en           = md_en;

endmodule

// File: doc/riscv_core_mdu_ctrl.md
Name: riscv_core_mdu_ctrl

Overview:
- Sequencing controller for the M-extension unit; sits between the EX-stage issue logic and the mul/div datapath (mul_div wrapper instance).
- Registers operands and drives the mul/div wrapper's operand, control, isword and enable inputs.
- Waits for the multi-cycle divider's done and holds the result for one done cycle.
- Resolves RISC-V divide-by-zero and signed-overflow cases in-line without starting the divider.
- Raises a pipeline stall for the whole operation and aborts cleanly on flush.

Parameters:
XLEN, 64, datapath width; also the width of every operand and result port.

Ports:
i_mdu_ctrl_clk  input  1  clock.
i_mdu_ctrl_rstn  input  1  asynchronous active-low reset.
i_mdu_ctrl_valid  input  1  EX holds an M-ext instruction; held high with stable operands until o_mdu_ctrl_done.
i_mdu_ctrl_funct3  input  3  RISC-V funct3: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
i_mdu_ctrl_isword  input  1  *W variant (RV64 32-bit op).
i_mdu_ctrl_srcA  input  XLEN  rs1 value.
i_mdu_ctrl_srcB  input  XLEN  rs2 value.
i_mdu_ctrl_flush  input  1  kill the in-flight op.
o_mdu_ctrl_stall  output  1  hold pipeline.
o_mdu_ctrl_done  output  1  one-cycle result valid.
o_mdu_ctrl_result  output  XLEN  result; meaningful only while done=1.
o_mdu_ctrl_busy  output  1  FSM not IDLE.
o_md_srcA  output  XLEN  to mul/div wrapper.
o_md_srcB  output  XLEN  to mul/div wrapper.
o_md_control  output  4  to wrapper, = {1'b0, funct3}; bit2 selects divide.
o_md_isword  output  1  to wrapper.
o_md_en  output  1  to wrapper enable.
i_md_done  input  1  from wrapper (divider done).
i_md_result  input  XLEN  from wrapper.

Behaviour:
- Reset (async, rstn=0):
  - State IDLE.
  - All registered outputs, the operand registers and the result register clear to 0.
  - Reset mid-operation abandons the op; no done is produced.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - valid and no flush: capture funct3, isword, srcA and srcB.
  - funct3[2]=0: go to MUL.
  - funct3[2]=1 and fast-path hit: load the fast result into the result register, go to DONE.
  - Otherwise: go to DIV.
- MUL:
  - en=1 for exactly one cycle.
  - Register i_md_result at the end of the cycle, go to DONE.
  - Multiplier is combinational in the wrapper.
- DIV:
  - en=1 every cycle.
  - On i_md_done: register i_md_result, go to DONE.
  - Done may arrive in the first DIV cycle; there is no timeout.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - New ops are accepted only in IDLE; back-to-back ops therefore have one bubble.
- Latency (cycle 0 = first cycle valid is seen in IDLE):
  - MUL*: done in cycle 2.
  - Fast-path divide: done in cycle 1.
  - Real divide: done in the cycle after i_md_done.
- stall = valid & ~done (combinational). It is 0 in the done cycle so EX advances.
- o_md_* driven from the captured registers; en=0 outside MUL/DIV.
- Fast path (divisor and dividend taken from the low 32 bits when isword):
  - Divisor zero:
    - DIV/DIVU: all ones.
    - REM/REMU: dividend; sign-extended from bit 31 when isword.
  - Signed overflow (DIV/REM, dividend = most-negative, divisor = -1):
    - DIV: dividend (sign-extended when isword).
    - REM: 0.
  - DIVU/REMU never overflow.
- Flush:
  - Any state, flush=1: next state IDLE, en forced 0 that cycle, no done.
  - Flush wins over a simultaneous i_md_done (result discarded) and over a simultaneous accept.
  - A flush in the DONE cycle has no effect: the result is already committed.
- Wrapper result is used as-is (the wrapper handles W sign-extension for non-fast ops).

Decomposition:
- Package riscv_core_pkg gets:
  - mdu_state_t enum {IDLE, MUL, DIV, DONE}.
  - funct3 localparams (F3_MUL ... F3_REMU).
- Sub-module riscv_core_div_fastpath (combinational): inputs srcA, srcB, funct3[1:0], isword; outputs hit and result.

Test Plan:
- MUL, srcA=7, srcB=-3 (64-bit), wrapper returns -21: done at cycle 2, result 0xFFFF_FFFF_FFFF_FFEB; stall high cycles 0-1, low in cycle 2.
- DIV, srcA=100, srcB=0: no en pulse; done at cycle 1, result 0xFFFF_FFFF_FFFF_FFFF. REMU, srcA=100, srcB=0: result 100.
- DIVW, srcA=0x8000_0000, srcB=0xFFFF_FFFF: done at cycle 1, result 0xFFFF_FFFF_8000_0000. REMW with the same operands: result 0.
- DIVU, srcA=1000, srcB=7, model raises i_md_done 20 cycles after en with result 142: en high 20 cycles, done the next cycle, result 142, busy low afterwards.
- DIV in progress, flush asserted in cycle 5 together with i_md_done: en low next cycle, FSM in IDLE, no done; a following MUL completes normally.
- rstn pulsed low mid-DIV: outputs go to 0 immediately (async); after release FSM is IDLE and a new op is accepted.
